// File: rtl/ram_port_arbiter_if.sv
// Bundle of the arbiter's requester, RAM and status signals.
// slave  = arbiter side, master = requesters plus RAM (system side).
interface ram_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   // requester port 0
   logic              p0_read;
   logic              p0_write;
   logic [ADDR_W-1:0] p0_addr;
   logic [DATA_W-1:0] p0_wdata;
   logic [DATA_W-1:0] p0_rdata;
   logic              p0_done;
   // requester port 1
   logic              p1_read;
   logic              p1_write;
   logic [ADDR_W-1:0] p1_addr;
   logic [DATA_W-1:0] p1_wdata;
   logic [DATA_W-1:0] p1_rdata;
   logic              p1_done;
   // single-port RAM
   logic [ADDR_W-1:0] ramAddress;
   logic [DATA_W-1:0] ramOut;
   logic              readReq;
   logic              writeReq;
   logic [DATA_W-1:0] ramIn;
   // status
   logic              busy;
   logic              owner;
   logic              proto_err;

   modport slave (
      input  p0_read, p0_write, p0_addr, p0_wdata,
      output p0_rdata, p0_done,
      input  p1_read, p1_write, p1_addr, p1_wdata,
      output p1_rdata, p1_done,
      output ramAddress, ramOut, readReq, writeReq,
      input  ramIn,
      output busy, owner, proto_err
   );

   modport master (
      output p0_read, p0_write, p0_addr, p0_wdata,
      input  p0_rdata, p0_done,
      output p1_read, p1_write, p1_addr, p1_wdata,
      input  p1_rdata, p1_done,
      input  ramAddress, ramOut, readReq, writeReq,
      output ramIn,
      input  busy, owner, proto_err
   );
endinterface

// File: rtl/ram_port_arbiter.sv
// Two-port arbiter in front of a single-port RAM with fixed read latency.
// One access in flight at a time: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
module ram_port_arbiter #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int RAM_LATENCY = 2,   // 1..15
   parameter int FIXED_PRIO  = 0
) (
   input logic               clk,
   input logic               reset,   // async, active low
   ram_port_arbiter_if.slave bus
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t            state, state_nxt;
   logic [3:0]        cnt;
   logic              op_wr;        // latched access type of the current grant
   logic              own;
   logic              rr_ptr;       // port favoured on the next tie
   logic              perr;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] rdata0_q, rdata1_q;

   logic pend0, pend1, grant, win, sample;
   logic read_req, write_req, busy_c, done0, done1;

   assign pend0 = bus.p0_read | bus.p0_write;
   assign pend1 = bus.p1_read | bus.p1_write;
   assign grant = (state == IDLE) && (pend0 || pend1);

   // the RAM data is valid on exactly one edge: E0 + RAM_LATENCY
   assign sample = ((state == ISSUE) && (RAM_LATENCY == 1)) ||
                   ((state == WAIT) && (cnt == 4'd0));

   // winner select: a lone requester always wins, ties go by mode
   always_comb begin
      win = 1'b0;
      if (pend0 && pend1)
         win = (FIXED_PRIO != 0) ? 1'b0 : rr_ptr;
      else if (pend1)
         win = 1'b1;
   end

   // state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (grant) state_nxt = ISSUE;
         ISSUE: state_nxt = (RAM_LATENCY == 1) ? DONE : WAIT;
         WAIT:  if (cnt == 4'd0) state_nxt = DONE;
         DONE:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // strobes, busy and done pulses decode straight from the state
   always_comb begin
      read_req  = (state == ISSUE) && !op_wr;
      write_req = (state == ISSUE) &&  op_wr;
      busy_c    = (state != IDLE);
      done0     = (state == DONE) && !own;
      done1     = (state == DONE) &&  own;
   end

   // grant capture, latency counter, read-data return and error flag
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt      <= '0;
         op_wr    <= 1'b0;
         own      <= 1'b0;
         rr_ptr   <= 1'b0;
         perr     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata0_q <= '0;
         rdata1_q <= '0;
      end else begin
         if (grant) begin
            own     <= win;
            rr_ptr  <= ~win;
            addr_q  <= win ? bus.p1_addr  : bus.p0_addr;
            wdata_q <= win ? bus.p1_wdata : bus.p0_wdata;
            // write takes precedence when a port raises both strobes
            op_wr   <= win ? bus.p1_write : bus.p0_write;
            if (win ? (bus.p1_read && bus.p1_write) : (bus.p0_read && bus.p0_write))
               perr <= 1'b1;
         end
         if (state == ISSUE)
            cnt <= 4'(RAM_LATENCY > 1 ? RAM_LATENCY - 2 : 0);
         else if (state == WAIT)
            cnt <= cnt - 4'd1;
         if (sample && !op_wr) begin
            if (own) rdata1_q <= bus.ramIn;
            else     rdata0_q <= bus.ramIn;
         end
      end
   end

   assign bus.ramAddress = addr_q;
   assign bus.ramOut     = wdata_q;
   assign bus.readReq    = read_req;
   assign bus.writeReq   = write_req;
   assign bus.busy       = busy_c;
   assign bus.owner      = own;
   assign bus.proto_err  = perr;
   assign bus.p0_rdata   = rdata0_q;
   assign bus.p1_rdata   = rdata1_q;
   assign bus.p0_done    = done0;
   assign bus.p1_done    = done1;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench: instance a is round-robin, instance b is fixed priority.
// Both use RAM_LATENCY = 2, so a read completes 3 edges after the request.
module tb_ram_port_arbiter;
   logic clk = 1'b0;
   logic reset = 1'b0;
   int   total = 0;
   int   bad = 0;
   logic [31:0] ram_data = 32'h0;
   logic [31:0] exp_p0;

   ram_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) a ();
   ram_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b ();

   ram_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RAM_LATENCY(2), .FIXED_PRIO(0))
      dut_rr (.clk(clk), .reset(reset), .bus(a));
   ram_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RAM_LATENCY(2), .FIXED_PRIO(1))
      dut_fx (.clk(clk), .reset(reset), .bus(b));

   always #5 clk = ~clk;

   // RAM models: read data valid only in the cycle after the readReq edge
   always @(posedge clk) begin
      a.ramIn <= a.readReq ? ram_data : 32'hBAD0BAD0;
      b.ramIn <= b.readReq ? ram_data : 32'hBAD0BAD0;
   end

   // waits for the next done pulse on a (sel_b=0) or b, drops that port's request
   task automatic wait_done(input bit sel_b, output int port, output int cyc);
      port = -1;
      cyc  = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (!sel_b && a.p0_done) begin port = 0; cyc = i; a.p0_read = 0; a.p0_write = 0; break; end
         if (!sel_b && a.p1_done) begin port = 1; cyc = i; a.p1_read = 0; a.p1_write = 0; break; end
         if ( sel_b && b.p0_done) begin port = 0; cyc = i; b.p0_read = 0; b.p0_write = 0; break; end
         if ( sel_b && b.p1_done) begin port = 1; cyc = i; b.p1_read = 0; b.p1_write = 0; break; end
      end
   endtask

   task automatic test_reset();
      {a.p0_read, a.p0_write, a.p1_read, a.p1_write} = '0;
      {b.p0_read, b.p0_write, b.p1_read, b.p1_write} = '0;
      a.p0_addr = '0; a.p0_wdata = '0; a.p1_addr = '0; a.p1_wdata = '0;
      b.p0_addr = '0; b.p0_wdata = '0; b.p1_addr = '0; b.p1_wdata = '0;
      reset = 1'b0;
      repeat (2) @(negedge clk);
      total++;
      if ({a.readReq, a.writeReq, a.busy, a.owner, a.proto_err, a.p0_done, a.p1_done} !== 7'b0 ||
          a.p0_rdata !== 32'h0 || a.p1_rdata !== 32'h0 || a.ramAddress !== 32'h0 || a.ramOut !== 32'h0) begin
         bad++;
         $display("FAIL reset_a got ctl=%b addr=%h out=%h want all 0",
                  {a.readReq, a.writeReq, a.busy, a.owner, a.proto_err, a.p0_done, a.p1_done},
                  a.ramAddress, a.ramOut);
      end
      total++;
      if ({b.readReq, b.writeReq, b.busy, b.owner, b.proto_err, b.p0_done, b.p1_done} !== 7'b0) begin
         bad++;
         $display("FAIL reset_b got ctl=%b want 0",
                  {b.readReq, b.writeReq, b.busy, b.owner, b.proto_err, b.p0_done, b.p1_done});
      end
      reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_read();
      ram_data = 32'hDEADBEEF;
      a.p0_read = 1; a.p0_addr = 32'h10;
      @(negedge clk);  // after E0
      total++;
      if ({a.readReq, a.writeReq, a.busy, a.owner} !== 4'b1010 || a.ramAddress !== 32'h10) begin
         bad++;
         $display("FAIL rd_issue got rq/wq/busy/own=%b addr=%h want 1010 addr=10",
                  {a.readReq, a.writeReq, a.busy, a.owner}, a.ramAddress);
      end
      a.p0_addr = 32'hFFFF;  // ignored while busy
      @(negedge clk);  // after E1
      total++;
      if ({a.readReq, a.p0_done} !== 2'b00) begin
         bad++;
         $display("FAIL rd_strobe_len got rq/done=%b want 00", {a.readReq, a.p0_done});
      end
      @(negedge clk);  // after E2
      total++;
      if (a.p0_done !== 1'b1 || a.p0_rdata !== 32'hDEADBEEF) begin
         bad++;
         $display("FAIL rd_done got done=%b rdata=%h want 1 deadbeef", a.p0_done, a.p0_rdata);
      end
      a.p0_read = 0;
      @(negedge clk);  // after E3
      total++;
      if ({a.p0_done, a.busy} !== 2'b00 || a.ramAddress !== 32'h10 || a.p0_rdata !== 32'hDEADBEEF) begin
         bad++;
         $display("FAIL rd_end got done/busy=%b addr=%h rdata=%h want 00 10 deadbeef",
                  {a.p0_done, a.busy}, a.ramAddress, a.p0_rdata);
      end
   endtask

   task automatic test_write();
      a.p1_write = 1; a.p1_addr = 32'h20; a.p1_wdata = 32'h55;
      @(negedge clk);
      total++;
      if ({a.readReq, a.writeReq, a.busy, a.owner} !== 4'b0111 ||
          a.ramAddress !== 32'h20 || a.ramOut !== 32'h55) begin
         bad++;
         $display("FAIL wr_issue got rq/wq/busy/own=%b addr=%h out=%h want 0111 20 55",
                  {a.readReq, a.writeReq, a.busy, a.owner}, a.ramAddress, a.ramOut);
      end
      @(negedge clk);
      total++;
      if ({a.writeReq, a.p1_done} !== 2'b00) begin
         bad++;
         $display("FAIL wr_strobe_len got wq/done=%b want 00", {a.writeReq, a.p1_done});
      end
      @(negedge clk);
      total++;
      if ({a.p1_done, a.p0_done} !== 2'b10 || a.p1_rdata !== 32'h0) begin
         bad++;
         $display("FAIL wr_done got p1/p0 done=%b p1_rdata=%h want 10 0",
                  {a.p1_done, a.p0_done}, a.p1_rdata);
      end
      a.p1_write = 0;
      @(negedge clk);
      total++;
      if ({a.p1_done, a.busy} !== 2'b00 || a.ramOut !== 32'h55) begin
         bad++;
         $display("FAIL wr_end got done/busy=%b out=%h want 00 55", {a.p1_done, a.busy}, a.ramOut);
      end
   endtask

   task automatic test_round_robin();
      int port, cyc;
      ram_data = 32'h11110030;
      a.p0_read = 1; a.p0_addr = 32'h30;
      a.p1_write = 1; a.p1_addr = 32'h40; a.p1_wdata = 32'h77;
      wait_done(1'b0, port, cyc);
      total++;
      if (port !== 0 || cyc !== 3 || a.owner !== 1'b0 || a.p0_rdata !== 32'h11110030) begin
         bad++;
         $display("FAIL rr_first got port=%0d cyc=%0d owner=%b rdata=%h want 0 3 0 11110030",
                  port, cyc, a.owner, a.p0_rdata);
      end
      // p0 comes straight back while p1 still waits: tie goes to p1
      ram_data = 32'h22220031;
      a.p0_read = 1; a.p0_addr = 32'h31;
      wait_done(1'b0, port, cyc);
      total++;
      if (port !== 1 || cyc !== 4 || a.owner !== 1'b1 || a.ramOut !== 32'h77) begin
         bad++;
         $display("FAIL rr_second got port=%0d cyc=%0d owner=%b out=%h want 1 4 1 77",
                  port, cyc, a.owner, a.ramOut);
      end
      wait_done(1'b0, port, cyc);
      total++;
      if (port !== 0 || a.owner !== 1'b0 || a.p0_rdata !== 32'h22220031 || a.ramAddress !== 32'h31) begin
         bad++;
         $display("FAIL rr_third got port=%0d owner=%b rdata=%h addr=%h want 0 0 22220031 31",
                  port, a.owner, a.p0_rdata, a.ramAddress);
      end
      exp_p0 = 32'h22220031;
      @(negedge clk);
   endtask

   task automatic test_fixed_prio();
      int port, cyc;
      b.p0_read = 1; b.p0_addr = 32'h80;
      b.p1_read = 1; b.p1_addr = 32'h90;
      for (int r = 0; r < 3; r++) begin
         wait_done(1'b1, port, cyc);
         total++;
         if (port !== 0 || b.owner !== 1'b0) begin
            bad++;
            $display("FAIL fx_p0_round%0d got port=%0d owner=%b want 0 0", r, port, b.owner);
         end
         if (r < 2) b.p0_read = 1;  // re-request immediately
      end
      ram_data = 32'h0000F1F1;
      wait_done(1'b1, port, cyc);
      total++;
      if (port !== 1 || b.owner !== 1'b1 || b.p1_rdata !== 32'h0000F1F1 || b.ramAddress !== 32'h90) begin
         bad++;
         $display("FAIL fx_p1_last got port=%0d owner=%b rdata=%h addr=%h want 1 1 f1f1 90",
                  port, b.owner, b.p1_rdata, b.ramAddress);
      end
      @(negedge clk);
   endtask

   task automatic test_proto_err();
      int port, cyc;
      total++;
      if (a.proto_err !== 1'b0) begin
         bad++;
         $display("FAIL perr_pre got %b want 0", a.proto_err);
      end
      a.p0_read = 1; a.p0_write = 1; a.p0_addr = 32'h50; a.p0_wdata = 32'h99;
      @(negedge clk);
      total++;
      if ({a.readReq, a.writeReq, a.proto_err} !== 3'b011 || a.ramOut !== 32'h99) begin
         bad++;
         $display("FAIL perr_issue got rq/wq/err=%b out=%h want 011 99",
                  {a.readReq, a.writeReq, a.proto_err}, a.ramOut);
      end
      wait_done(1'b0, port, cyc);
      total++;
      if (port !== 0 || a.p0_rdata !== exp_p0) begin
         bad++;
         $display("FAIL perr_done got port=%0d rdata=%h want 0 %h", port, a.p0_rdata, exp_p0);
      end
      ram_data = 32'h33330058;
      a.p1_read = 1; a.p1_addr = 32'h58;
      wait_done(1'b0, port, cyc);
      total++;
      if (port !== 1 || a.proto_err !== 1'b1 || a.p1_rdata !== 32'h33330058) begin
         bad++;
         $display("FAIL perr_sticky got port=%0d err=%b rdata=%h want 1 1 33330058",
                  port, a.proto_err, a.p1_rdata);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_midflight();
      int port, cyc, seen;
      ram_data = 32'hCAFEF00D;
      a.p0_read = 1; a.p0_addr = 32'h60;
      repeat (2) @(negedge clk);  // now in WAIT
      reset = 1'b0;
      a.p0_read = 0;
      #1;
      total++;
      if ({a.readReq, a.writeReq, a.busy, a.owner, a.proto_err, a.p0_done, a.p1_done} !== 7'b0 ||
          a.p0_rdata !== 32'h0 || a.p1_rdata !== 32'h0 || a.ramAddress !== 32'h0) begin
         bad++;
         $display("FAIL rst_mid got ctl=%b p0=%h p1=%h addr=%h want all 0",
                  {a.readReq, a.writeReq, a.busy, a.owner, a.proto_err, a.p0_done, a.p1_done},
                  a.p0_rdata, a.p1_rdata, a.ramAddress);
      end
      seen = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (a.p0_done) seen++;
      end
      reset = 1'b1;
      ram_data = 32'h0BADCAFE;
      a.p1_read = 1; a.p1_addr = 32'h70;
      wait_done(1'b0, port, cyc);
      total++;
      if (seen !== 0 || port !== 1 || cyc !== 3 || a.p1_rdata !== 32'h0BADCAFE || a.p0_rdata !== 32'h0) begin
         bad++;
         $display("FAIL rst_after got stray=%0d port=%0d cyc=%0d p1=%h p0=%h want 0 1 3 0badcafe 0",
                  seen, port, cyc, a.p1_rdata, a.p0_rdata);
      end
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_read();
      test_write();
      test_round_robin();
      test_fixed_prio();
      test_proto_err();
      test_reset_midflight();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
